top_nco_cnt_disp: RTL and testbench
===================================

// Module: top_nco_cnt_disp
// PURPOSE
//  Top level of the NCO/counter/display block: 1 Hz time base from the system clock,
//  MM:SS counter, shown on a 6-digit multiplexed 7-segment display.
//  Sits directly under the board pad ring; outputs drive segment and digit-enable pins.
// PARAMETERS
//  NCO_NUM   50_000_000  clk cycles per count tick (1 Hz at 50 MHz)
//  SCAN_DIV  50_000      clk cycles per digit in the display scan (1 ms per digit)
//  NCO_W     32          accumulator width; NCO_NUM and SCAN_DIV must be < 2**NCO_W
// PORTS
//  clk        in   1  system clock, 50 MHz, rising edge
//  rst_n      in   1  reset, asynchronous, active-high (1 = reset); name kept per codebase
//  o_seg      out  7  segments, active-high, [0]=a .. [6]=g
//  o_seg_dp   out  1  decimal point, active-high
//  o_seg_enb  out  6  digit enables, active-low one-hot, [0]=rightmost digit
// BEHAVIOUR
//  - Reset: all state cleared asynchronously.
//    Output values during reset:
//      o_seg=7'h00, o_seg_dp=0, o_seg_enb=6'h3F (all digits off).
//    Counters, NCO accumulator and scan index are all 0.
//  - NCO: acc counts 0..NCO_NUM-1.
//    tick=1 for exactly one clk in the cycle where acc==NCO_NUM-1, then acc wraps to 0.
//    First tick falls in clk cycle NCO_NUM after reset release.
//  - Counter: on tick, sec increments.
//    When sec==59: sec->0 and min increments.
//    When min==59 and sec==59: both ->0 (wrap 59:59 -> 00:00).
//    No other event changes sec or min.
//  - Digit map (BCD):
//      d0 = sec%10, d1 = sec/10, d2 = min%10, d3 = min/10.
//      d4 and d5 are blank (all segments off).
//  - Decoder, digits 0-9 (hex):
//      3F 06 5B 4F 66 6D 7D 07 7F 6F.
//    Codes above 9 or a blank digit give 00.
//  - Scan:
//    - scan counter runs 0..SCAN_DIV-1.
//    - On wrap, digit index advances 0,1,..,5,0.
//    - o_seg, o_seg_dp and o_seg_enb are registered and update together.
//      There is one clk latency from an index change to the outputs.
//    - Exactly one o_seg_enb bit is low at any time after the first cycle following reset.
//  - o_seg_dp is 0 on every digit except d2 (minute/second separator).
//    For d2 its value is set by the optional feature below.
//  - A tick and a scan advance in the same clk are independent.
//    A displayed digit reflects the counter value registered at output-update time.
//  - Reset asserted mid-count: immediate return to the reset state.
//    After release, counting restarts from 00:00.
// CONFIGURATION
//  DP_BLINK_EN defined:
//    - o_seg_dp on d2 = blink register.
//    - Blink register toggles on every tick.
//    - Reset value 0, so the first tick lights it.
//  DP_BLINK_EN undefined: o_seg_dp on d2 is constant 1.
//  In both cases o_seg_dp is 0 on all other digits.
// STRUCTURE
//  Shared package nco_disp_pkg:
//  - segment code constants SEG_0..SEG_9, SEG_BLANK
//  - digit count NUM_DIGITS=6
//  - typedef for 4-bit BCD digit
//  Sub-module nco: parameters NCO_NUM and NCO_W; ports clk, rst_n, o_tick.
//  Counter, BCD split, decoder and scan mux live in the top.
// TESTING (bench overrides NCO_NUM=10, SCAN_DIV=4)
//  1. Reset held 3 clk.
//     -> o_seg_enb=3F, o_seg=00, o_seg_dp=0.
//     After release, within 2 clk, o_seg_enb=3E and o_seg=3F ('0').
//  2. Run 10 clk after release.
//     -> one-clk tick.
//     Display d0 then shows 06 ('1'), d1..d3 show 3F.
//  3. Run 60 ticks.
//     -> sec wraps 59->0, min=1.
//     d2 shows 06, d1 and d0 show 3F.
//  4. Run 3600 ticks.
//     -> 59:59 -> 00:00.
//     All numeric digits 3F.
//     d4 and d5 always show o_seg=00.
//  5. Scan check over 24 clk.
//     -> o_seg_enb cycles 3E,3D,3B,37,2F,1F, each held 4 clk, always one-hot-low.
//     o_seg_dp is high only while enb=3B (with DP_BLINK_EN: only after odd tick counts).
//  6. Assert reset mid-count (at 00:37).
//     -> outputs go to reset values in the same cycle, without a clock edge.
//     After release, counting resumes from 00:00.

Source files
------------

// File: rtl/nco_disp_pkg.sv
// Shared constants and helpers for the NCO / MM:SS counter / 7-segment display block.
package nco_disp_pkg;

    localparam int NUM_DIGITS = 6;

    typedef logic [3:0] bcd_t;

    // Segment codes, active-high, bit 0 = segment a .. bit 6 = segment g
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Any code above 9 decodes to blank; blank digit positions carry this one
    localparam bcd_t BCD_BLANK = 4'hF;

    function automatic logic [6:0] seg_decode(bcd_t d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/top_nco_cnt_disp_nco.sv
// Time-base NCO: pulses o_tick for one clk every NCO_NUM clk cycles.
module nco #(
    parameter int NCO_NUM = 50_000_000,
    parameter int NCO_W   = 32
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_tick
);

    localparam logic [NCO_W-1:0] ACC_LAST = NCO_W'(NCO_NUM - 1);

    logic [NCO_W-1:0] acc;

    assign o_tick = (acc == ACC_LAST);

    // rst_n is active-high despite its name
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)       acc <= '0;
        else if (o_tick) acc <= '0;
        else             acc <= acc + NCO_W'(1);
    end

endmodule

// File: rtl/top_nco_cnt_disp.sv
// MM:SS counter on a 6-digit multiplexed 7-segment display, driven by a 1 Hz NCO tick.
// Optional DP_BLINK_EN: the separator dot on d2 blinks with each tick instead of staying lit.
module top_nco_cnt_disp
    import nco_disp_pkg::*;
#(
    parameter int NCO_NUM  = 50_000_000,
    parameter int SCAN_DIV = 50_000,
    parameter int NCO_W    = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [6:0] o_seg,
    output logic       o_seg_dp,
    output logic [5:0] o_seg_enb
);

    localparam logic [NCO_W-1:0] SCAN_LAST = NCO_W'(SCAN_DIV - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(NUM_DIGITS - 1);

    logic             tick;
    logic [5:0]       sec_cnt;
    logic [5:0]       min_cnt;
    logic [NCO_W-1:0] scan_cnt;
    logic [2:0]       idx;
    bcd_t             digit;
    logic             dp;
    logic             dp_sep;

    nco #(
        .NCO_NUM (NCO_NUM),
        .NCO_W   (NCO_W)
    ) u_nco (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_tick (tick)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sec_cnt <= '0;
            min_cnt <= '0;
        end else if (tick) begin
            if (sec_cnt == 6'd59) begin
                sec_cnt <= '0;
                min_cnt <= (min_cnt == 6'd59) ? 6'd0 : min_cnt + 6'd1;
            end else begin
                sec_cnt <= sec_cnt + 6'd1;
            end
        end
    end

`ifdef DP_BLINK_EN
    logic blink;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)     blink <= 1'b0;
        else if (tick) blink <= ~blink;
    end

    assign dp_sep = blink;
`else
    assign dp_sep = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + NCO_W'(1);
        end
    end

    always_comb begin
        digit = BCD_BLANK;
        dp    = 1'b0;
        case (idx)
            3'd0: digit = 4'(sec_cnt % 6'd10);
            3'd1: digit = 4'(sec_cnt / 6'd10);
            3'd2: begin
                digit = 4'(min_cnt % 6'd10);
                dp    = dp_sep;
            end
            3'd3: digit = 4'(min_cnt / 6'd10);
            default: digit = BCD_BLANK;
        endcase
    end

    // Segments, dot and enables are registered together so the pins change in one edge
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            o_seg     <= SEG_BLANK;
            o_seg_dp  <= 1'b0;
            o_seg_enb <= 6'h3F;
        end else begin
            o_seg     <= seg_decode(digit);
            o_seg_dp  <= dp;
            o_seg_enb <= ~(6'b000001 << idx);
        end
    end

endmodule

// File: tb/tb_top_nco_cnt_disp.sv
// Self-checking bench for top_nco_cnt_disp; expected display derived from elapsed clk count.
module tb_top_nco_cnt_disp;

    localparam int NCO_NUM  = 10;
    localparam int SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] enb;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    top_nco_cnt_disp #(
        .NCO_NUM  (NCO_NUM),
        .SCAN_DIV (SCAN_DIV),
        .NCO_W    (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .o_seg     (seg),
        .o_seg_dp  (dp),
        .o_seg_enb (enb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h n=%0d", tag, obs, exp, n);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_enb"}, 32'(enb), 32'h3F);
        chk({tag, "_seg"}, 32'(seg), 32'h00);
        chk({tag, "_dp"},  32'(dp),  32'h0);
    endtask

    // Reference: after the n-th edge since release the pins show the digit selected
    // and the time accumulated before that edge.
    task automatic check_model();
        int         t, s, m, dsel;
        logic [6:0] es;
        logic       ed;
        logic [5:0] ee;
        t    = (n - 1) / NCO_NUM;
        s    = t % 60;
        m    = (t / 60) % 60;
        dsel = ((n - 1) / SCAN_DIV) % 6;
        case (dsel)
            0:       es = seg_tbl[s % 10];
            1:       es = seg_tbl[s / 10];
            2:       es = seg_tbl[m % 10];
            3:       es = seg_tbl[m / 10];
            default: es = 7'h00;
        endcase
`ifdef DP_BLINK_EN
        ed = (dsel == 2) ? ((t % 2) == 1) : 1'b0;
`else
        ed = (dsel == 2);
`endif
        ee       = 6'h3F;
        ee[dsel] = 1'b0;
        chk("seg", 32'(seg), 32'(es));
        chk("enb", 32'(enb), 32'(ee));
        chk("dp", 32'(dp), 32'(ed));
        chk("onehot", 32'($countones(~enb)), 32'd1);
        chk("tick", 32'(dut.u_nco.o_tick), 32'((n % NCO_NUM) == NCO_NUM - 1));
    endtask

    task automatic step();
        @(posedge clk);
        n++;
        @(negedge clk);
        check_model();
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    // Assert reset between edges and check the outputs clear before any clock edge
    task automatic mid_reset(input string tag);
        #2 rst_n = 1'b1;
        #1 check_reset({tag, "_async"});
        repeat ($urandom_range(1, 4)) begin
            @(negedge clk);
            check_reset({tag, "_hold"});
        end
        rst_n = 1'b0;
        n     = 0;
    endtask

    initial begin
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_reset("por");
        end
        rst_n = 1'b0;
        n     = 0;

        step();
        chk("first_enb", 32'(enb), 32'h3E);
        chk("first_seg", 32'(seg), 32'h3F);

        // Past 60 ticks (01:00) and past 3600 ticks (wrap to 00:00)
        run(36000 + $urandom_range(0, 60));

        mid_reset("rand_rst");
        run(NCO_NUM * 37 + $urandom_range(1, NCO_NUM - 1));
        chk("at_0037", 32'((n - 1) / NCO_NUM), 32'd37);

        mid_reset("rst_0037");
        run(200 + $urandom_range(0, 100));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
